// File: rtl/perf_counter_unit.sv
// Performance-monitor unit for the 5-stage RV32I pipeline.
// Wide cycle/instret counters plus NUM_HPM selectable event counters,
// per-counter inhibit, sticky overflow with interrupt, and a snapshot
// shadow bank so that lo/hi reads of a counter are always coherent.
module perf_counter_unit #(
    parameter int CNT_W   = 48,
    parameter int NUM_EVT = 8,
    parameter int NUM_HPM = 4,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic              cfg_wr_en,
    input  logic              cfg_rd_en,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              cfg_rvalid,
    output logic              ovf_irq
);

    // Counter index 0 = cycle, 1 = instret, 2+k = HPMk; this is also the
    // bit layout of INHIBIT, OVF and IRQ_EN.
    localparam int NUM_CTR = NUM_HPM + 2;

    localparam logic [ADDR_W-1:0] A_INH  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_OVF  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_IEN  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_SNAP = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_SEL  = ADDR_W'(32);

    logic [CNT_W-1:0]   cnt_q [NUM_CTR];
    logic [CNT_W-1:0]   cnt_d [NUM_CTR];
    logic [CNT_W-1:0]   shd_q [NUM_CTR];
    logic [NUM_CTR-1:0] inhibit_q;
    logic [NUM_CTR-1:0] ovf_q;
    logic [NUM_CTR-1:0] ovf_d;
    logic [NUM_CTR-1:0] ovf_set;
    logic [NUM_CTR-1:0] irq_en_q;
    logic [NUM_CTR-1:0] hit;
    logic [NUM_CTR-1:0] wr_lo;
    logic [NUM_CTR-1:0] wr_hi;
    logic [NUM_HPM-1:0] wr_sel;
    logic [3:0]         sel_q [NUM_HPM];
    logic [15:0]        evt_ext;
    logic [31:0]        rd_mux;
    logic               wr_inh;
    logic               wr_ovf;
    logic               wr_ien;
    logic               wr_snap;

    function automatic logic [ADDR_W-1:0] lo_addr(input int i);
        return (i < 2) ? ADDR_W'(2 * i) : ADDR_W'(16 + 2 * (i - 2));
    endfunction

    function automatic logic [ADDR_W-1:0] hi_addr(input int i);
        return (i < 2) ? ADDR_W'(2 * i + 1) : ADDR_W'(17 + 2 * (i - 2));
    endfunction

    // Decode the register-port write strobe into per-register enables.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_lo   = '0;
        wr_hi   = '0;
        wr_sel  = '0;
        wr_inh  = cfg_wr_en && (cfg_addr == A_INH);
        wr_ovf  = cfg_wr_en && (cfg_addr == A_OVF);
        wr_ien  = cfg_wr_en && (cfg_addr == A_IEN);
        wr_snap = cfg_wr_en && (cfg_addr == A_SNAP);
        for (int i = 0; i < NUM_CTR; i++) begin
            wr_lo[i] = cfg_wr_en && (cfg_addr == lo_addr(i));
            wr_hi[i] = cfg_wr_en && (cfg_addr == hi_addr(i));
        end
        for (int k = 0; k < NUM_HPM; k++) begin
            wr_sel[k] = cfg_wr_en && (cfg_addr == A_SEL + ADDR_W'(k));
        end
    end

    // Per-counter increment request; a selector of 0 or beyond NUM_EVT lands
    // on a constant-zero bit of evt_ext, so it never counts.
    always_comb begin
        evt_ext              = '0;
        evt_ext[NUM_EVT:1]   = evt_i;
        hit                  = '0;
        hit[0]               = 1'b1;
        hit[1]               = retire_i;
        for (int k = 0; k < NUM_HPM; k++) begin
            hit[2+k] = evt_ext[sel_q[k]];
        end
    end

    // Next counter values: a register write beats the increment and never
    // flags overflow; a wrap from all-ones flags overflow on the same edge.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_lo[i]) begin
                cnt_d[i][31:0] = cfg_wdata;
            end else if (wr_hi[i]) begin
                cnt_d[i][CNT_W-1:32] = cfg_wdata[CNT_W-33:0];
            end else if (hit[i] && !inhibit_q[i]) begin
                cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                ovf_set[i] = &cnt_q[i];
            end
        end
        // A fresh overflow wins over a simultaneous write-1-to-clear.
        ovf_d = (ovf_q & ~(wr_ovf ? cfg_wdata[NUM_CTR-1:0] : '0)) | ovf_set;
    end

    // Read mux: counters come from the shadow bank, control registers live.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (cfg_addr == lo_addr(i)) rd_mux = shd_q[i][31:0];
            if (cfg_addr == hi_addr(i)) rd_mux = 32'(shd_q[i] >> 32);
        end
        if (cfg_addr == A_INH) rd_mux = 32'(inhibit_q);
        if (cfg_addr == A_OVF) rd_mux = 32'(ovf_q);
        if (cfg_addr == A_IEN) rd_mux = 32'(irq_en_q);
        for (int k = 0; k < NUM_HPM; k++) begin
            if (cfg_addr == A_SEL + ADDR_W'(k)) rd_mux = 32'(sel_q[k]);
        end
    end

    // Live counters and their snapshot shadows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the counter and shadow arrays are architecturally visible, so every entry is reset explicitly.
            for (int i = 0; i < NUM_CTR; i++) begin
                cnt_q[i] <= '0;
                shd_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so the snapshot captures the pre-increment values of this edge.
            for (int i = 0; i < NUM_CTR; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (wr_snap) shd_q[i] <= cnt_q[i];
            end
        end
    end

    // Control registers: inhibit, sticky overflow, interrupt enable, selectors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inhibit_q <= '0;
            ovf_q     <= '0;
            irq_en_q  <= '0;
            for (int k = 0; k < NUM_HPM; k++) sel_q[k] <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (wr_inh) inhibit_q <= cfg_wdata[NUM_CTR-1:0];
            if (wr_ien) irq_en_q  <= cfg_wdata[NUM_CTR-1:0];
            for (int k = 0; k < NUM_HPM; k++) begin
                if (wr_sel[k]) sel_q[k] <= cfg_wdata[3:0];
            end
        end
    end

    // Registered read port: one-cycle latency, data held between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_rdata  <= '0;
            cfg_rvalid <= 1'b0;
        end else begin
            cfg_rvalid <= cfg_rd_en;
            if (cfg_rd_en) cfg_rdata <= rd_mux;
        end
    end

    assign ovf_irq = |(ovf_q & irq_en_q);

endmodule
